// File: rtl/mc_ctrl_pkg.sv
// Shared encodings and the packed control word for the multicycle controller.
// MC_CTRL_BNE_EN (optional) adds the BNEST state; its encoding is always reserved here.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_EXC     = 4'd12,
    S_BNEST   = 4'd13
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       exc;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  // Raw register values outside the enum collapse to EXC so stray encodings recover via the exception path.
  function automatic state_e to_state(input logic [31:0] raw);
    if (raw > 32'(S_BNEST)) return S_EXC;
    return state_e'(raw[3:0]);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Output decoder: maps (state, opcode, mem_ready) to the datapath control word.
// MC_CTRL_BNE_EN adds the bne_o strobe for the BNEST state.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 5
) (
  input  logic [ST_W-1:0] state_i,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
`ifdef MC_CTRL_BNE_EN
  output logic            bne_o,
`endif
  output ctrl_t           ctrl_o
);

  logic is_andi;
  logic is_ori;

  assign is_andi = (op_i == OP_W'(OP_ANDI));
  assign is_ori  = (op_i == OP_W'(OP_ORI));

  always_comb begin
    ctrl_o = '0;
`ifdef MC_CTRL_BNE_EN
    bne_o  = 1'b0;
`endif
    case (to_state(32'(state_i)))
      S_FETCH: begin
        ctrl_o.alusrcb = 2'b01;
        ctrl_o.aluop   = ALU_ADD;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = 2'b11;
        ctrl_o.aluop   = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
        ctrl_o.aluop   = ALU_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.branch  = 1'b1;
        ctrl_o.pcsrc   = 2'b01;
        ctrl_o.aluop   = ALU_SUB;
      end
      S_IEXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
        ctrl_o.aluop   = is_andi ? ALU_AND : (is_ori ? ALU_OR : ALU_ADD);
      end
      S_IWB: ctrl_o.regwrite = 1'b1;
      S_JUMP: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = 2'b10;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEST: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.pcsrc   = 2'b01;
        ctrl_o.aluop   = ALU_SUB;
        bne_o          = 1'b1;
      end
`endif
      default: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = 2'b11;
        ctrl_o.exc     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU controller: state register, next-state logic and output decoder.
// Define MC_CTRL_BNE_EN to add the BNEST state and the bne output.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ST_W    = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic               branch,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               exc,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
`ifdef MC_CTRL_BNE_EN
  output logic               bne,
`endif
  output logic [ST_W-1:0]    state_o
);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  ctrl_t           ctrl;

  logic is_lw, is_sw, is_rtype, is_beq, is_imm, is_j, is_bne;

  assign is_lw    = (op == OP_W'(OP_LW));
  assign is_sw    = (op == OP_W'(OP_SW));
  assign is_rtype = (op == OP_W'(OP_RTYPE));
  assign is_beq   = (op == OP_W'(OP_BEQ));
  assign is_imm   = (op == OP_W'(OP_ADDI)) || (op == OP_W'(OP_ANDI)) || (op == OP_W'(OP_ORI));
  assign is_j     = (op == OP_W'(OP_J));
  assign is_bne   = (op == OP_W'(OP_BNE));

  // mem_ready: the memory finishes the pending access in any cycle it is high; FETCH/MEMRD/MEMWR hold until then.
  always_comb begin
    state_d = ST_W'(S_FETCH);
    case (to_state(32'(state_q)))
      S_FETCH:   state_d = mem_ready ? ST_W'(S_DECODE) : ST_W'(S_FETCH);
      S_DECODE: begin
        if (is_lw || is_sw)   state_d = ST_W'(S_MEMADR);
        else if (is_rtype)    state_d = ST_W'(S_EXECUTE);
        else if (is_beq)      state_d = ST_W'(S_BRANCH);
        else if (is_imm)      state_d = ST_W'(S_IEXEC);
        else if (is_j)        state_d = ST_W'(S_JUMP);
`ifdef MC_CTRL_BNE_EN
        else if (is_bne)      state_d = ST_W'(S_BNEST);
`endif
        else                  state_d = ST_W'(S_EXC);
      end
      S_MEMADR: begin
        if (is_lw)            state_d = ST_W'(S_MEMRD);
        else if (is_sw)       state_d = ST_W'(S_MEMWR);
        else                  state_d = ST_W'(S_EXC);
      end
      S_MEMRD:   state_d = mem_ready ? ST_W'(S_MEMWB) : ST_W'(S_MEMRD);
      S_MEMWR:   state_d = mem_ready ? ST_W'(S_FETCH) : ST_W'(S_MEMWR);
      S_EXECUTE: state_d = ST_W'(S_ALUWB);
      S_IEXEC:   state_d = ST_W'(S_IWB);
      default:   state_d = ST_W'(S_FETCH);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_W'(S_FETCH);
    else        state_q <= state_d;
  end

  mc_ctrl_outdec #(.OP_W(OP_W), .ST_W(ST_W)) u_outdec (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
`ifdef MC_CTRL_BNE_EN
    .bne_o       (bne),
`endif
    .ctrl_o      (ctrl)
  );

`ifndef MC_CTRL_BNE_EN
  // BNE is decoded only when the BNEST state exists; otherwise it takes the exception path.
  logic unused_bne;
  assign unused_bne = is_bne;
`endif

  assign pcwrite  = ctrl.pcwrite;
  assign memwrite = ctrl.memwrite;
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign branch   = ctrl.branch;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign exc      = ctrl.exc;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ALUOP_W'(ctrl.aluop);
  assign state_o  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle traces (state + strobes) built from the
// instruction-class rules, replayed cycle by cycle against the DUT. Honours MC_CTRL_BNE_EN.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  // record = {op[29:24], mem_ready[23], state[22:18], ctl[17:0]}
  localparam int W = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst, exc;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [4:0] state_o;
  logic       bne_obs;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  mc_ctrl_fsm #(.OP_W(6), .ST_W(5), .ALUOP_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .branch(branch), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .exc(exc), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
`ifdef MC_CTRL_BNE_EN
    .bne(bne_obs),
`endif
    .state_o(state_o)
  );

`ifndef MC_CTRL_BNE_EN
  assign bne_obs = 1'b0;
`endif

  // ---------------- reference model ----------------
  function automatic logic [17:0] ctl(input state_e s, input logic [5:0] o, input logic mr);
    logic pw, mw, iw, rw, asa, br, io, mtr, rd, ex, bn;
    logic [1:0] asb, ps;
    logic [2:0] ao;
    {pw, mw, iw, rw, asa, br, io, mtr, rd, ex, bn} = '0;
    asb = 2'b00; ps = 2'b00; ao = 3'd0;
    case (s)
      S_FETCH:   begin asb = 2'b01; iw = mr; pw = mr; end
      S_DECODE:  asb = 2'b11;
      S_MEMADR:  begin asa = 1'b1; asb = 2'b10; end
      S_MEMRD:   io = 1'b1;
      S_MEMWB:   begin rw = 1'b1; mtr = 1'b1; end
      S_MEMWR:   begin io = 1'b1; mw = 1'b1; end
      S_EXECUTE: begin asa = 1'b1; ao = 3'd2; end
      S_ALUWB:   begin rd = 1'b1; rw = 1'b1; end
      S_BRANCH:  begin asa = 1'b1; br = 1'b1; ps = 2'b01; ao = 3'd1; end
      S_IEXEC: begin
        asa = 1'b1; asb = 2'b10;
        ao = (o == 6'b001100) ? 3'd3 : ((o == 6'b001101) ? 3'd4 : 3'd0);
      end
      S_IWB:     rw = 1'b1;
      S_JUMP:    begin pw = 1'b1; ps = 2'b10; end
      S_BNEST:   begin asa = 1'b1; bn = 1'b1; ps = 2'b01; ao = 3'd1; end
      default:   begin pw = 1'b1; ps = 2'b11; ex = 1'b1; end
    endcase
    return {pw, mw, iw, rw, asa, br, io, mtr, rd, ex, bn, asb, ps, ao};
  endfunction

  task automatic push(input state_e s, input logic [5:0] o, input logic mr);
    exp_q.push_back({o, mr, 5'(s), ctl(s, o, mr)});
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Whole instruction: fetch waits, decode, then the class-specific tail.
  task automatic build(input logic [5:0] o, input int wf, input int wm);
    for (int i = 0; i < wf; i++) push(S_FETCH, o, 1'b0);
    push(S_FETCH, o, 1'b1);
    push(S_DECODE, o, rnd_bit());
    case (o)
      6'b100011: begin
        push(S_MEMADR, o, rnd_bit());
        for (int i = 0; i < wm; i++) push(S_MEMRD, o, 1'b0);
        push(S_MEMRD, o, 1'b1);
        push(S_MEMWB, o, rnd_bit());
      end
      6'b101011: begin
        push(S_MEMADR, o, rnd_bit());
        for (int i = 0; i < wm; i++) push(S_MEMWR, o, 1'b0);
        push(S_MEMWR, o, 1'b1);
      end
      6'b000000: begin push(S_EXECUTE, o, rnd_bit()); push(S_ALUWB, o, rnd_bit()); end
      6'b000100: push(S_BRANCH, o, rnd_bit());
      6'b001000, 6'b001100, 6'b001101: begin push(S_IEXEC, o, rnd_bit()); push(S_IWB, o, rnd_bit()); end
      6'b000010: push(S_JUMP, o, rnd_bit());
`ifdef MC_CTRL_BNE_EN
      6'b000101: push(S_BNEST, o, rnd_bit());
`endif
      default:   push(S_EXC, o, rnd_bit());
    endcase
  endtask

  // ---------------- driver / scoreboard ----------------
  function automatic logic [22:0] observed();
    return {state_o, pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg,
            regdst, exc, bne_obs, alusrcb, pcsrc, aluop};
  endfunction

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (state obs=%0d exp=%0d)", tag, obs, expv, obs[22:18], expv[22:18]);
    end
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] rec;
    while (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      @(negedge clk);
      op        = rec[29:24];
      mem_ready = rec[23];
      #1;
      chk(tag, observed(), rec[22:0]);
    end
  endtask

  task automatic run(input string tag, input logic [5:0] o, input int wf, input int wm);
    build(o, wf, wm);
    drain(tag);
  endtask

  // Enter a memory wait state, then assert reset while still waiting.
  task automatic reset_mid(input string tag, input logic [5:0] o, input state_e wait_s);
    push(S_FETCH, o, 1'b1);
    push(S_DECODE, o, rnd_bit());
    push(S_MEMADR, o, rnd_bit());
    push(wait_s, o, 1'b0);
    push(wait_s, o, 1'b0);
    drain(tag);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1 chk({tag, "_pre"}, observed(), {5'(wait_s), ctl(wait_s, o, 1'b0)});
    @(negedge clk);
    #1 chk({tag, "_fetch"}, observed(), {5'(S_FETCH), ctl(S_FETCH, o, 1'b0)});
    chk({tag, "_strobes"}, {21'd0, memwrite, regwrite}, 23'd0);
    reset = 1'b1;
    @(negedge clk);
    #1 chk({tag, "_after"}, observed(), {5'(S_FETCH), ctl(S_FETCH, o, 1'b0)});
  endtask

  // ---------------- directed + random sequence ----------------
  logic [5:0] op_tab [0:9];

  initial begin
    op_tab[0] = 6'b100011; op_tab[1] = 6'b101011; op_tab[2] = 6'b000000;
    op_tab[3] = 6'b000100; op_tab[4] = 6'b001000; op_tab[5] = 6'b001100;
    op_tab[6] = 6'b001101; op_tab[7] = 6'b000010; op_tab[8] = 6'b000101;
    op_tab[9] = 6'b111111;

    reset = 1'b0; mem_ready = 1'b0; op = 6'b100011;
    repeat (2) @(negedge clk);
    #1 chk("reset_state", observed(), {5'(S_FETCH), ctl(S_FETCH, op, 1'b0)});
    mem_ready = 1'b1;
    #1 chk("reset_fetch_ready", observed(), {5'(S_FETCH), ctl(S_FETCH, op, 1'b1)});
    @(negedge clk);
    #1 chk("reset_hold", observed(), {5'(S_FETCH), ctl(S_FETCH, op, 1'b1)});
    reset = 1'b1; mem_ready = 1'b0;

    run("lw_ready",   6'b100011, 0, 0);
    run("sw_wait3",   6'b101011, 0, 3);
    run("illegal_op", 6'b111111, 0, 0);
    run("ori",        6'b001101, 0, 0);
    run("bne",        6'b000101, 0, 0);
    run("rtype",      6'b000000, 1, 0);
    run("beq",        6'b000100, 0, 0);
    run("jump",       6'b000010, 2, 0);
    run("addi",       6'b001000, 0, 0);
    run("andi",       6'b001100, 0, 0);
    run("lw_wait",    6'b100011, 1, 2);

    reset_mid("rst_memrd", 6'b100011, S_MEMRD);
    reset_mid("rst_memwr", 6'b101011, S_MEMWR);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      if ($urandom_range(0, 4) == 0) o = 6'($urandom_range(0, 63));
      else o = op_tab[$urandom_range(0, 9)];
      run("random", o, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    push(S_FETCH, 6'b000000, 1'b0);
    drain("final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
